// File: rtl/fdiv_nr_seq_pkg.sv
// Shared FP package: FMA opcodes, sequencer states, ftype codes
// and the operand/destination selects used by the NR divider.
package fdiv_nr_seq_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,
        OP_FNMA1 = 2'd1,
        OP_FMA   = 2'd2,
        OP_FMAH  = 2'd3
    } fma_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] FTYPE_SGL = 2'b00;
    localparam logic [1:0] FTYPE_DBL = 2'b01;
    localparam logic [1:0] FTYPE_PS  = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        SRC_ZERO = 3'd0,
        SRC_X    = 3'd1,
        SRC_E    = 3'd2,
        SRC_T    = 3'd3,
        SRC_OPA  = 3'd4,
        SRC_OPB  = 3'd5
    } src_e;

    typedef enum logic [1:0] {
        DST_X   = 2'd0,
        DST_E   = 2'd1,
        DST_T   = 2'd2,
        DST_RES = 2'd3
    } dst_e;

    typedef struct packed {
        logic [67:0] x;
        logic [67:0] e;
        logic [67:0] t;
        logic [67:0] opa;
        logic [67:0] opb;
    } regs_t;

    function automatic logic [67:0] pick(src_e s, regs_t r);
        case (s)
            SRC_X:   return r.x;
            SRC_E:   return r.e;
            SRC_T:   return r.t;
            SRC_OPA: return r.opa;
            SRC_OPB: return r.opb;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/fdiv_nr_seq_if.sv
// Request/response channel between the NR sequencer and the FMA.
interface fdiv_nr_seq_if;

    logic        fma_req;
    logic        fma_gnt;
    logic [1:0]  fma_op;
    logic [67:0] fma_a;
    logic [67:0] fma_b;
    logic [67:0] fma_c;
    logic        fma_vld;
    logic [67:0] fma_res;

    modport master (
        output fma_req, fma_op, fma_a, fma_b, fma_c,
        input  fma_gnt, fma_vld, fma_res
    );

    modport slave (
        input  fma_req, fma_op, fma_a, fma_b, fma_c,
        output fma_gnt, fma_vld, fma_res
    );

endinterface

// File: rtl/fdiv_nr_seq_step.sv
// Iteration/step counters and the op-select table of the NR sequence.
module fdiv_nr_step
    import fdiv_nr_seq_pkg::*;
#(
    parameter int ITER_D = 3,
    parameter int ITER_S = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    input  logic       is_sqrt,
    input  logic [1:0] ftype,
    output fma_op_e    op,
    output src_e       sel_a,
    output src_e       sel_b,
    output src_e       sel_c,
    output dst_e       dst,
    output logic       last
);

    logic [1:0]       step;
    logic [CNT_W-1:0] iter;
    logic             iter_end;

    // iter counts remaining iterations; zero means the final multiply
    assign last     = (iter == '0);
    assign iter_end = is_sqrt ? (step == 2'd2) : (step == 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            step <= '0;
            iter <= '0;
        end else if (load) begin
            step <= '0;
            iter <= (ftype == FTYPE_DBL) ? CNT_W'(ITER_D)
                                         : CNT_W'(ITER_S);
        end else if (advance && !last) begin
            if (iter_end) begin
                step <= '0;
                iter <= iter - CNT_W'(1);
            end else begin
                step <= step + 2'd1;
            end
        end
    end

    always_comb begin
        op    = OP_MUL;
        sel_a = SRC_X;
        sel_b = SRC_X;
        sel_c = SRC_ZERO;
        dst   = DST_RES;
        unique case (1'b1)
            last: begin
                sel_a = is_sqrt ? SRC_OPB : SRC_OPA;
            end
            (!last && !is_sqrt && step == 2'd0): begin
                op    = OP_FNMA1;
                sel_a = SRC_OPB;
                dst   = DST_E;
            end
            (!last && !is_sqrt && step == 2'd1): begin
                op    = OP_FMA;
                sel_b = SRC_E;
                sel_c = SRC_X;
                dst   = DST_X;
            end
            (!last && is_sqrt && step == 2'd0): begin
                dst = DST_T;
            end
            (!last && is_sqrt && step == 2'd1): begin
                op    = OP_FNMA1;
                sel_a = SRC_OPB;
                sel_b = SRC_T;
                dst   = DST_E;
            end
            (!last && is_sqrt && step == 2'd2): begin
                op    = OP_FMAH;
                sel_b = SRC_E;
                sel_c = SRC_X;
                dst   = DST_X;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/fdiv_nr_seq.sv
// Newton-Raphson divide/sqrt sequencer driving a shared FMA.
// Define FDIV_NR_FLUSH_EN to add the flush port and stale-result discard.
module fdiv_nr_seq
    import fdiv_nr_seq_pkg::*;
#(
    parameter int ITER_D = 3,
    parameter int ITER_S = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_sqrt,
    input  logic [67:0]         seed,
    input  logic [67:0]         opA,
    input  logic [67:0]         opB,
`ifdef FDIV_NR_FLUSH_EN
    input  logic                flush,
`endif
    fdiv_nr_seq_if.master       fma,
    output logic                busy,
    output logic                done,
    output logic [67:0]         res
);

    state_e  state;
    state_e  state_nxt;
    regs_t   r;
    logic    sqrt_q;
    logic    accept;
    logic    wr;
    logic    cancel;
    logic    discard;
    fma_op_e op_sel;
    src_e    sel_a;
    src_e    sel_b;
    src_e    sel_c;
    dst_e    dst;
    logic    last;

`ifdef FDIV_NR_FLUSH_EN
    logic set_discard;

    assign cancel      = flush;
    // a result already returning this cycle leaves nothing to swallow
    assign set_discard = (state == ST_WAIT) && flush && !fma.fma_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            discard <= 1'b0;
        end else if (set_discard) begin
            discard <= 1'b1;
        end else if (fma.fma_vld) begin
            discard <= 1'b0;
        end
    end
`else
    assign cancel  = 1'b0;
    assign discard = 1'b0;
`endif

    fdiv_nr_step #(
        .ITER_D (ITER_D),
        .ITER_S (ITER_S)
    ) u_step (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .advance (wr),
        .is_sqrt (sqrt_q),
        .ftype   (seed[67:66]),
        .op      (op_sel),
        .sel_a   (sel_a),
        .sel_b   (sel_b),
        .sel_c   (sel_c),
        .dst     (dst),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wr        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && !discard) begin
                    accept    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cancel) begin
                    state_nxt = ST_IDLE;
                end else if (fma.fma_gnt) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cancel) begin
                    state_nxt = ST_IDLE;
                end else if (fma.fma_vld) begin
                    wr        = 1'b1;
                    state_nxt = last ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r      <= '0;
            sqrt_q <= 1'b0;
            res    <= '0;
        end else begin
            if (accept) begin
                r.x    <= seed;
                r.opa  <= opA;
                r.opb  <= opB;
                sqrt_q <= is_sqrt;
            end
            if (wr) begin
                case (dst)
                    DST_X:   r.x <= fma.fma_res;
                    DST_E:   r.e <= fma.fma_res;
                    DST_T:   r.t <= fma.fma_res;
                    default: res <= fma.fma_res;
                endcase
            end
        end
    end

    always_comb begin
        fma.fma_req = 1'b0;
        fma.fma_op  = 2'd0;
        fma.fma_a   = '0;
        fma.fma_b   = '0;
        fma.fma_c   = '0;
        if (state == ST_ISSUE) begin
            fma.fma_req = 1'b1;
            fma.fma_op  = op_sel;
            fma.fma_a   = pick(sel_a, r);
            fma.fma_b   = pick(sel_b, r);
            fma.fma_c   = pick(sel_c, r);
        end
    end

    assign busy = (state == ST_ISSUE) || (state == ST_WAIT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_fdiv_nr_seq.sv
// Bench for fdiv_nr_seq: behavioural NR op-sequence model plus a
// configurable FMA responder; directed cases then random operations.
module tb_fdiv_nr_seq;
    import fdiv_nr_seq_pkg::*;

    localparam int ITD = 3;
    localparam int ITS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_sqrt;
    logic [67:0] seed;
    logic [67:0] opA;
    logic [67:0] opB;
    logic        busy;
    logic        done;
    logic [67:0] res;
`ifdef FDIV_NR_FLUSH_EN
    logic        flush;
`endif

    fdiv_nr_seq_if fma();

    fdiv_nr_seq #(
        .ITER_D (ITD),
        .ITER_S (ITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .is_sqrt (is_sqrt),
        .seed    (seed),
        .opA     (opA),
        .opB     (opB),
`ifdef FDIV_NR_FLUSH_EN
        .flush   (flush),
`endif
        .fma     (fma.master),
        .busy    (busy),
        .done    (done),
        .res     (res)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string n, logic [67:0] act, logic [67:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, expv);
        end
    endtask

    task automatic chk_i(string n, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, expv);
        end
    endtask

    // Stand-in FMA arithmetic: any fixed mixing function will do
    function automatic logic [67:0] fma_f(logic [1:0] op, logic [67:0] a,
                                          logic [67:0] b, logic [67:0] c);
        logic [67:0] rv;
        rv = {a[40:0], a[67:41]} ^ (b * 68'd5) ^ {c[66:0], c[67]};
        rv = rv ^ {66'd0, op};
        return rv + 68'h9E3779B97F4A7C15A;
    endfunction

    function automatic logic [67:0] rnd68();
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        return w[67:0];
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [67:0] a;
        logic [67:0] b;
        logic [67:0] c;
    } req_t;

    req_t        exp_q[$];
    logic [67:0] exp_res;
    bit          active = 0;
    int          exp_ops;
    int          op_cnt;
    bit          done_seen;
    int          seen_ops[$];
    int          held_log[$];

    // Algorithm-level model of the whole operation
    task automatic expect_op(bit sq, logic [1:0] ft, logic [67:0] s,
                             logic [67:0] a, logic [67:0] b);
        logic [67:0] x;
        logic [67:0] e;
        logic [67:0] t;
        int n;
        x = s;
        n = (ft == FTYPE_DBL) ? ITD : ITS;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (!sq) begin
                e = fma_f(2'd1, b, x, '0);
                exp_q.push_back('{2'd1, b, x, 68'd0});
                exp_q.push_back('{2'd2, x, e, x});
                x = fma_f(2'd2, x, e, x);
            end else begin
                t = fma_f(2'd0, x, x, '0);
                exp_q.push_back('{2'd0, x, x, 68'd0});
                e = fma_f(2'd1, b, t, '0);
                exp_q.push_back('{2'd1, b, t, 68'd0});
                exp_q.push_back('{2'd3, x, e, x});
                x = fma_f(2'd3, x, e, x);
            end
        end
        if (sq) begin
            exp_q.push_back('{2'd0, b, x, 68'd0});
            exp_res = fma_f(2'd0, b, x, '0);
        end else begin
            exp_q.push_back('{2'd0, a, x, 68'd0});
            exp_res = fma_f(2'd0, a, x, '0);
        end
        exp_ops   = exp_q.size();
        op_cnt    = 0;
        done_seen = 0;
        seen_ops.delete();
        held_log.delete();
        active    = 1;
    endtask

    // FMA responder: grant after gnt_delay req cycles, answer after lat
    int          gnt_delay = 0;
    int          lat = 4;
    bit          in_flight = 0;
    int          wcnt = 0;
    int          lcnt = 0;
    logic [67:0] pend;

    initial begin
        fma.fma_gnt = 1'b0;
        fma.fma_vld = 1'b0;
        fma.fma_res = '0;
        forever begin
            @(posedge clk);
            #1;
            fma.fma_gnt = 1'b0;
            fma.fma_vld = 1'b0;
            if (in_flight) begin
                lcnt--;
                if (lcnt <= 0) begin
                    fma.fma_vld = 1'b1;
                    fma.fma_res = pend;
                    in_flight   = 0;
                end
            end else if (fma.fma_req) begin
                if (wcnt >= gnt_delay) begin
                    fma.fma_gnt = 1'b1;
                    pend = fma_f(fma.fma_op, fma.fma_a, fma.fma_b, fma.fma_c);
                    in_flight = 1;
                    lcnt = lat;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Compare process
    int          held = 0;
    int          last_vld_cyc = 0;
    logic [1:0]  p_op;
    logic [67:0] p_a;
    logic [67:0] p_b;
    logic [67:0] p_c;

    always @(negedge clk) begin
        req_t ex;
        if (!rst) begin
            if (fma.fma_vld) last_vld_cyc = cyc;
            if (fma.fma_req) begin
                if (held > 0) begin
                    chk("req_stable", {fma.fma_op, fma.fma_a[65:0]},
                        {p_op, p_a[65:0]});
                    chk("req_stable_bc", fma.fma_b ^ fma.fma_c, p_b ^ p_c);
                end
                if (fma.fma_gnt) begin
                    if (!active || exp_q.size() == 0) begin
                        chk_i("unexpected_req", 1, 0);
                    end else begin
                        ex = exp_q.pop_front();
                        chk("op", 68'(fma.fma_op), 68'(ex.op));
                        chk("opnd_a", fma.fma_a, ex.a);
                        chk("opnd_b", fma.fma_b, ex.b);
                        chk("opnd_c", fma.fma_c, ex.c);
                    end
                    seen_ops.push_back(int'(fma.fma_op));
                    held_log.push_back(held);
                    op_cnt++;
                    held = 0;
                end else begin
                    held++;
                    p_op = fma.fma_op;
                    p_a  = fma.fma_a;
                    p_b  = fma.fma_b;
                    p_c  = fma.fma_c;
                end
            end else begin
                held = 0;
            end
            if (done) begin
                done_seen = 1;
                if (!active) begin
                    chk_i("unexpected_done", 1, 0);
                end else begin
                    chk("res", res, exp_res);
                    chk_i("op_count", op_cnt, exp_ops);
                    chk_i("done_lat", cyc - last_vld_cyc, 1);
                end
                active = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(bit sq, logic [1:0] ft, logic [67:0] a,
                          logic [67:0] b);
        logic [67:0] s;
        s       = rnd68();
        s       = {ft, s[65:0]};
        is_sqrt = sq;
        seed    = s;
        opA     = a;
        opB     = b;
        expect_op(sq, ft, s, a, b);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(string n, int budget);
        int k;
        k = 0;
        while (!done_seen && k < budget) begin
            tick();
            k++;
        end
        chk_i(n, int'(done_seen), 1);
        chk_i({n, "_idle"}, int'({busy, done}), 0);
    endtask

    task automatic wait_ops(int n, int budget);
        int k;
        k = 0;
        while (op_cnt < n && k < budget) begin
            tick();
            k++;
        end
        chk_i("wait_ops", op_cnt, n);
    endtask

    initial begin
        int div_d[7] = '{1, 2, 1, 2, 1, 2, 0};
        int sq_s[7]  = '{0, 1, 3, 0, 1, 3, 0};
        rst     = 1'b1;
        start   = 1'b0;
        is_sqrt = 1'b0;
        seed    = '0;
        opA     = '0;
        opB     = '0;
`ifdef FDIV_NR_FLUSH_EN
        flush   = 1'b0;
`endif
        repeat (3) tick();
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_done", int'(done), 0);
        chk_i("rst_req", int'(fma.fma_req), 0);
        chk("rst_op", 68'(fma.fma_op), 68'd0);
        chk("rst_abc", fma.fma_a | fma.fma_b | fma.fma_c, 68'd0);
        chk("rst_res", res, 68'd0);
        rst = 1'b0;
        tick();

        // spurious vld in IDLE
        fma.fma_vld = 1'b1;
        fma.fma_res = rnd68();
        tick();
        chk_i("spur_busy", int'(busy), 0);
        chk_i("spur_done", int'(done), 0);
        tick();
        chk_i("spur_done2", int'(done), 0);
        chk("spur_res", res, 68'd0);

        // double divide, immediate grant, latency 4
        gnt_delay = 0;
        lat = 4;
        launch(0, FTYPE_DBL, rnd68(), rnd68());
        wait_done("div_d_done", 400);
        chk_i("div_d_n", seen_ops.size(), 7);
        for (int i = 0; i < 7 && i < seen_ops.size(); i++)
            chk_i("div_d_seq", seen_ops[i], div_d[i]);

        // single sqrt, grant delayed 3 cycles
        gnt_delay = 3;
        lat = 2;
        launch(1, FTYPE_PS, rnd68(), rnd68());
        wait_done("sq_s_done", 400);
        chk_i("sq_s_n", seen_ops.size(), 7);
        for (int i = 0; i < 7 && i < seen_ops.size(); i++) begin
            chk_i("sq_s_seq", seen_ops[i], sq_s[i]);
            chk_i("sq_s_held", held_log[i], 3);
        end

        // remaining op counts
        gnt_delay = 1;
        lat = 3;
        launch(1, FTYPE_DBL, rnd68(), rnd68());
        wait_done("sq_d_done", 400);
        chk_i("sq_d_n", seen_ops.size(), 10);
        launch(0, FTYPE_SGL, rnd68(), rnd68());
        wait_done("div_s_done", 400);
        chk_i("div_s_n", seen_ops.size(), 5);

        // start while busy is ignored
        gnt_delay = 0;
        lat = 4;
        launch(0, FTYPE_DBL, rnd68(), rnd68());
        repeat (5) tick();
        opA   = rnd68();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_start_done", 400);

        // reset during WAIT of op 3
        launch(0, FTYPE_DBL, rnd68(), rnd68());
        wait_ops(3, 100);
        chk_i("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        active = 0;
        exp_q.delete();
        chk_i("mid_rst_busy", int'(busy), 0);
        chk_i("mid_rst_req", int'(fma.fma_req), 0);
        chk_i("mid_rst_done", int'(done), 0);
        rst = 1'b0;
        launch(1, FTYPE_PS, rnd68(), rnd68());
        chk_i("restart_busy", int'(busy), 1);
        wait_done("restart_done", 400);

`ifdef FDIV_NR_FLUSH_EN
        gnt_delay = 0;
        lat = 4;
        launch(0, FTYPE_DBL, rnd68(), rnd68());
        wait_ops(1, 100);
        chk_i("pre_flush_busy", int'(busy), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        active = 0;
        exp_q.delete();
        chk_i("flush_idle", int'(busy), 0);
        opA   = rnd68();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_i("flush_start_blocked", int'(busy), 0);
        for (int k = 0; k < 20 && in_flight; k++) tick();
        tick();
        launch(0, FTYPE_DBL, rnd68(), rnd68());
        chk_i("post_flush_busy", int'(busy), 1);
        wait_done("post_flush_done", 400);
`endif

        // randomized operations
        for (int n = 0; n < 30; n++) begin
            gnt_delay = int'($urandom_range(0, 2));
            lat       = int'($urandom_range(1, 5));
            launch(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   rnd68(), rnd68());
            wait_done("rand_done", 400);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fdiv_nr_seq.md
FDIV_NR_SEQ -- requirements
Module: fdiv_nr_seq

Interface
REQ-001 Parameter ITER_D, default 3, meaning Newton-Raphson iterations for double-precision operands.
REQ-002 Parameter ITER_S, default 2, meaning Newton-Raphson iterations for packed-single operands.
REQ-003 Port clk  input  1  clock; all state changes on posedge clk.
REQ-004 Port rst  input  1  reset rst, synchronous, active-high.
REQ-005 Port start  input  1  accept new operation (seed valid).
REQ-006 Port is_sqrt  input  1  operation is square root; else divide.
REQ-007 Port seed  input  68  reciprocal / reciprocal-sqrt estimate from the permute stage; [67:66] ftype.
REQ-008 Port opA  input  68  dividend (unused for sqrt).
REQ-009 Port opB  input  68  divisor / sqrt operand.
REQ-010 Port flush  input  1  cancel current operation (present only with FDIV_NR_FLUSH_EN).
REQ-011 Port fma_req  output  1  request to FMA unit; held until granted.
REQ-012 Port fma_gnt  input  1  FMA accepts request this cycle.
REQ-013 Port fma_op  output  2  0 MUL a*b; 1 FNMA1 1-a*b; 2 FMA c+a*b; 3 FMAH c+0.5*a*b.
REQ-014 Port fma_a, fma_b, fma_c  output  68 each  FMA operands.
REQ-015 Port fma_vld  input  1  FMA result valid.
REQ-016 Port fma_res  input  68  FMA result.
REQ-017 Port busy  output  1  operation in progress.
REQ-018 Port done  output  1  one-cycle result strobe.
REQ-019 Port res  output  68  final quotient / root; held until next done.

Function
REQ-020 States SHALL be IDLE, ISSUE, WAIT, DONE; busy=1 in ISSUE and WAIT.
REQ-021 IDLE with start=1: latch seed into x, opA, opB, is_sqrt, ftype; load iteration counter (ITER_D if ftype==`ftype_dbl else ITER_S); step=0; go ISSUE.
REQ-022 start while busy or in DONE SHALL be ignored.
REQ-023 Divide iteration SHALL issue: step0 FNMA1(a=opB,b=x) -> e; step1 FMA(a=x,b=e,c=x) -> x.
REQ-024 Sqrt iteration SHALL issue: step0 MUL(x,x) -> t; step1 FNMA1(opB,t) -> e; step2 FMAH(a=x,b=e,c=x) -> x.
REQ-025 After last iteration one final op SHALL issue: divide MUL(opA,x); sqrt MUL(opB,x).
REQ-026 ISSUE: fma_req=1 with stable operands; on fma_gnt go WAIT next cycle; fma_req=0 outside ISSUE.
REQ-027 At most one FMA op outstanding; fma_vld in IDLE/ISSUE SHALL be ignored.
REQ-028 WAIT with fma_vld: write fma_res to t/e/x per step, advance step/counter, return to ISSUE; on final op capture into res and go DONE.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; total ops: double div 7, single div 5, double sqrt 10, single sqrt 7 (defaults).
REQ-030 fma_gnt and fma_vld in same cycle in ISSUE: gnt handled, vld ignored.
REQ-031 Operand vectors SHALL be passed unmodified as 68-bit words; lane handling of packed singles belongs to the FMA.

Reset
REQ-032 rst SHALL force IDLE; busy, done, fma_req, fma_op, fma_a/b/c, res, discard flag all zero; rst overrides start, flush, fma_vld in the same cycle.
REQ-033 rst mid-operation SHALL abandon the operation without a done pulse.

Configuration
REQ-034 Macro FDIV_NR_FLUSH_EN defined: flush port exists; flush in ISSUE -> IDLE next cycle; flush in WAIT -> IDLE and set discard flag, which swallows the next fma_vld then clears; flush in DONE suppresses nothing (done still pulses); start accepted in the cycle after flush only if discard flag is clear.
REQ-035 Macro undefined: no flush port, no discard flag; operations always run to completion.

Structure
REQ-036 fma_op encodings, FSM state encoding, and ftype constants SHALL live in the shared FP package.
REQ-037 Iteration/step counter and op-select table SHALL be one sub-module fdiv_nr_step producing fma_op and operand selects from {is_sqrt, step, last}.

Verification
REQ-038 Double divide, seed ftype dbl, bench FMA latency 4, gnt immediate -> 7 ops in order FNMA1,FMA x3 then MUL(opA,x); done 1 cycle after 7th vld; res = 7th fma_res.
REQ-039 Single sqrt, FMA gnt delayed 3 cycles each -> fma_req held stable 3 cycles per op; 7 ops MUL,FNMA1,FMAH x2 then MUL(opB,x).
REQ-040 start pulsed while busy with different opA -> ignored; res reflects original opA path.
REQ-041 rst asserted during WAIT of op 3 -> next cycle busy=0, fma_req=0, no done; new start accepted next cycle.
REQ-042 FDIV_NR_FLUSH_EN: flush in WAIT, stale fma_vld 2 cycles later, new start -> stale result discarded, new op sequence correct.
REQ-043 Spurious fma_vld in IDLE -> no state change, done stays 0.
